det5x5_seq_ctrl: RTL and testbench

- Sequential controller that computes a 5x5 signed determinant by cofactor expansion along row 0, using one shared external 4x4 determinant unit over five passes.
- Replaces five parallel 4x4 instances with one instance driven by this block.
- Sits between the matrix-operation front end (start/done handshake) and the 4x4 determinant datapath.

---
 rtl/det5x5_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_det5x5_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/det5x5_seq_ctrl.sv
// Sequential 5x5 determinant controller driving one shared 4x4 det unit.
// Optional DET5_SKIP_ZERO_EN: skip columns whose row-0 element is zero.
module det5x5_seq_ctrl #(
  parameter int DET4_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [199:0] matriz_5x5,
  output logic [127:0] minor_4x4,
  input  logic [31:0]  det4_in,
  output logic         busy,
  output logic         done,
  output logic [31:0]  det
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, ACC, DONE
  } state_t;

  localparam logic [3:0] LAT = 4'(DET4_LAT);

  state_t              state, state_nxt;
  logic [2:0]          k;
  logic [3:0]          cnt;
  logic [31:0]         acc;
  logic [199:0]        mat;
  logic signed [7:0]   ak;
  logic signed [39:0]  prod;
  logic [31:0]         term;
  logic [31:0]         acc_add;
  logic                last;
  logic                skip;

  function automatic logic [127:0] build_minor(
    input logic [199:0] m,
    input logic [2:0]   col
  );
    logic [127:0] v;
    int idx;
    v   = '0;
    idx = 0;
    for (int r = 1; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (c[2:0] != col) begin
          v[127-8*idx -: 8] = m[199-8*(5*r+c) -: 8];
          idx++;
        end
      end
    end
    return v;
  endfunction

  always_comb begin
    ak = '0;
    unique case (k)
      3'd0: ak = mat[199:192];
      3'd1: ak = mat[191:184];
      3'd2: ak = mat[183:176];
      3'd3: ak = mat[175:168];
      3'd4: ak = mat[167:160];
      default: ak = '0;
    endcase
  end

  // Full-width product, truncated; odd columns carry a negative cofactor sign
  assign prod    = ak * $signed(det4_in);
  assign term    = k[0] ? (32'd0 - prod[31:0]) : prod[31:0];
  assign acc_add = acc + term;
  assign last    = (k == 3'd4);

`ifdef DET5_SKIP_ZERO_EN
  assign skip = (ak == 8'sd0);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: begin
        if (skip)
          state_nxt = last ? DONE : ISSUE;
        else
          state_nxt = (LAT == 4'd0) ? ACC : WAIT;
      end
      WAIT:  if (cnt <= 4'd1) state_nxt = ACC;
      ACC:   state_nxt = last ? DONE : ISSUE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      cnt       <= '0;
      acc       <= '0;
      mat       <= '0;
      minor_4x4 <= '0;
      det       <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            mat <= matriz_5x5;
            k   <= '0;
            acc <= '0;
          end
        end
        ISSUE: begin
          if (!skip) begin
            minor_4x4 <= build_minor(mat, k);
            cnt       <= LAT;
          end else if (!last) begin
            k <= k + 3'd1;
          end
        end
        WAIT: cnt <= cnt - 4'd1;
        ACC: begin
          acc <= acc_add;
          if (!last) k <= k + 3'd1;
        end
        default: ;
      endcase
      // Result is captured on the edge that enters DONE
      if (state_nxt == DONE && state != DONE)
        det <= (state == ACC) ? acc_add : acc;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_det5x5_seq_ctrl.sv
// Directed bench for det5x5_seq_ctrl with a behavioural 1-cycle 4x4 det unit.
module tb_det5x5_seq_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [199:0] matriz_5x5;
  logic [127:0] minor_4x4;
  logic [31:0]  det4_in;
  logic         busy;
  logic         done;
  logic [31:0]  det;

  int errors = 0;
  int checks = 0;

  det5x5_seq_ctrl #(.DET4_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .matriz_5x5 (matriz_5x5),
    .minor_4x4  (minor_4x4),
    .det4_in    (det4_in),
    .busy       (busy),
    .done       (done),
    .det        (det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint det3(
    input longint a, input longint b, input longint c,
    input longint d, input longint e, input longint f,
    input longint g, input longint h, input longint i
  );
    return a*(e*i-f*h) - b*(d*i-f*g) + c*(d*h-e*g);
  endfunction

  function automatic longint det4(input logic [127:0] mn);
    longint x[4][4];
    longint s;
    int cs[3];
    int n;
    logic signed [7:0] e;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        e = mn[127-8*(4*r+c) -: 8];
        x[r][c] = longint'(e);
      end
    s = 0;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      for (int c = 0; c < 4; c++)
        if (c != j) begin
          cs[n] = c;
          n++;
        end
      s += ((j % 2) ? -1 : 1) * x[0][j] * det3(
        x[1][cs[0]], x[1][cs[1]], x[1][cs[2]],
        x[2][cs[0]], x[2][cs[1]], x[2][cs[2]],
        x[3][cs[0]], x[3][cs[1]], x[3][cs[2]]);
    end
    return s;
  endfunction

  // External 4x4 unit model: one register stage
  always @(posedge clk) det4_in <= 32'(det4(minor_4x4));

  function automatic logic [199:0] put(
    input logic [199:0] m, input int r, input int c, input logic [7:0] v
  );
    m[199-8*(5*r+c) -: 8] = v;
    return m;
  endfunction

  function automatic logic [199:0] diag(
    input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
    input logic [7:0] d, input logic [7:0] e
  );
    logic [199:0] m;
    m = '0;
    m = put(m, 0, 0, a);
    m = put(m, 1, 1, b);
    m = put(m, 2, 2, c);
    m = put(m, 3, 3, d);
    m = put(m, 4, 4, e);
    return m;
  endfunction

  function automatic int col_cost(input logic [199:0] m, input int c);
    logic [7:0] a;
    a = m[199-8*c -: 8];
`ifdef DET5_SKIP_ZERO_EN
    return (a == 8'd0) ? 1 : 3;
`else
    return (a == 8'd0) ? 3 : 3;
`endif
  endfunction

  function automatic int exp_lat(input logic [199:0] m);
    int t;
    t = 0;
    for (int c = 0; c < 5; c++) t += col_cost(m, c);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(
    input logic [199:0] m, input logic [31:0] exp_det, input string tag,
    input bit poke, input logic [199:0] other,
    input bit chkmin, input logic [127:0] expmin
  );
    int lat, medge, n;
    bit seen;
    lat   = exp_lat(m);
    medge = col_cost(m, 0) + 1;
    @(negedge clk);
    matriz_5x5 = m;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    matriz_5x5 = ~m;
    chk({tag, "_busy"}, 128'(busy), 128'(1'b1));
    n    = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (poke && n == 5) begin
        start      = 1'b1;
        matriz_5x5 = other;
      end
      if (poke && n == 7) start = 1'b0;
      if (chkmin && n == medge) chk({tag, "_minor"}, minor_4x4, expmin);
      if (done) seen = 1'b1;
    end
    chk({tag, "_lat"}, 128'(seen ? n : -1), 128'(lat));
    chk({tag, "_det"}, 128'(det), 128'(exp_det));
    @(posedge clk);
    #1;
    chk({tag, "_doneoff"}, 128'({done, busy}), 128'(2'b00));
  endtask

  logic [199:0] ident, swp, m35, mall2;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    matriz_5x5 = '0;
    ident = diag(8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    swp   = put(put(put(put(ident, 0, 0, 8'd0), 1, 1, 8'd0), 0, 1, 8'd1),
                1, 0, 8'd1);
    m35 = diag(8'd0, 8'd7, 8'd1, 8'd1, 8'd1);
    m35 = put(put(put(put(m35, 0, 4, 8'd5), 1, 1, 8'd0), 1, 0, 8'd7), 4, 4,
              8'd0);
    m35 = put(put(put(put(m35, 2, 2, 8'd0), 2, 1, 8'd1), 3, 3, 8'd0), 3, 2,
              8'd1);
    m35 = put(m35, 4, 3, 8'd1);
    mall2 = '0;
    for (int c = 0; c < 5; c++) mall2 = put(mall2, 0, c, 8'd2);
    for (int r = 1; r < 5; r++) mall2 = put(mall2, r, r - 1, 8'd1);

    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_done", 128'(done), 128'(1'b0));
    chk("rst_det", 128'(det), 128'(0));
    chk("rst_minor", minor_4x4, 128'(0));
    rst = 1'b0;

    run(ident, 32'd1, "ident", 1'b0, '0, 1'b0, '0);
    run(diag(8'd2, 8'd3, 8'd1, 8'd1, 8'd1), 32'd6, "diag23", 1'b0, '0,
        1'b0, '0);
    run(swp, 32'hFFFF_FFFF, "swap", 1'b0, '0, 1'b1,
        128'h01000000_00010000_00000100_00000001);
    run(diag(8'd127, 8'd127, 8'd127, 8'd127, 8'd127), 32'hB13D_827F,
        "wrap127", 1'b0, '0, 1'b0, '0);
    run(ident, 32'd1, "ignore", 1'b1, diag(8'd2, 8'd3, 8'd1, 8'd1, 8'd1),
        1'b0, '0);
    run(diag(8'd2, 8'd3, 8'd1, 8'd1, 8'd1), 32'd6, "second", 1'b0, '0,
        1'b0, '0);

    // Reset while waiting on column 2
    @(negedge clk);
    matriz_5x5 = mall2;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy), 128'(1'b0));
    chk("midrst_done", 128'(done), 128'(1'b0));
    chk("midrst_det", 128'(det), 128'(0));
    chk("midrst_minor", minor_4x4, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    run(mall2, 32'd2, "afterrst", 1'b0, '0, 1'b0, '0);

    run(m35, 32'd35, "k4only", 1'b0, '0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
